multi_gate_array: RTL

Parametrised, clocked successor to the quad 2-input gate packages in the 74LSXX library. It provides CHANNELS independent gates, each with INPUTS inputs. All gates share one runtime-selectable logic function. The propagation delay is modelled as a synthesizable pipeline of DELAY_CYC registers rather than a `#` delay, so the block can be used in the Digital_Clock datapath on hardware. An optional per-channel glitch filter can be compiled in.

---
 rtl/gate_array_pkg.sv | 55 +++++
 rtl/multi_gate_array_if.sv | 22 ++
 rtl/gate_glitch_filter.sv | 40 ++++
 rtl/multi_gate_array.sv | 96 +++++++++
 4 files changed

// File: rtl/gate_array_pkg.sv
// Shared types and helpers for the multi_gate_array block.
//   gate_fn_t  : 3-bit code of the eight logic functions shared by all gates
//   gate_eval  : reduces the low n bits of a gate's inputs with a function
//   FCNT_W     : width of a glitch-filter counter, sized for the largest
//                FILTER_CYC the block supports (15)
package gate_array_pkg;

  typedef enum logic [2:0] {
    FN_AND  = 3'd0,
    FN_OR   = 3'd1,
    FN_XOR  = 3'd2,
    FN_NAND = 3'd3,
    FN_NOR  = 3'd4,
    FN_XNOR = 3'd5,
    FN_BUF  = 3'd6,
    FN_INV  = 3'd7
  } gate_fn_t;

  localparam int MAX_INPUTS     = 8;
  localparam int FILTER_CYC_MAX = 15;
  localparam int FCNT_W         = $clog2(FILTER_CYC_MAX + 1);

  // Only the low n bits take part; XOR/XNOR are odd/even parity over them.
  function automatic logic gate_eval(input gate_fn_t fn,
                                     input logic [MAX_INPUTS-1:0] bits,
                                     input int n);
    logic v_and;
    logic v_or;
    logic v_xor;
    logic v_res;
    v_and = 1'b1;
    v_or  = 1'b0;
    v_xor = 1'b0;
    for (int i = 0; i < MAX_INPUTS; i++) begin
      if (i < n) begin
        v_and = v_and & bits[i];
        v_or  = v_or  | bits[i];
        v_xor = v_xor ^ bits[i];
      end
    end
    v_res = 1'b0;
    case (fn)
      FN_AND:  v_res = v_and;
      FN_OR:   v_res = v_or;
      FN_XOR:  v_res = v_xor;
      FN_NAND: v_res = ~v_and;
      FN_NOR:  v_res = ~v_or;
      FN_XNOR: v_res = ~v_xor;
      FN_BUF:  v_res = bits[0];
      FN_INV:  v_res = ~bits[0];
    endcase
    return v_res;
  endfunction

endpackage

// File: rtl/multi_gate_array_if.sv
// Bus bundle for multi_gate_array.
//   a        : gate inputs, channel c input i at bit c*INPUTS+i
//   en       : pipeline advance enable
//   fn_sel   : function code to load
//   fn_load  : load strobe for fn_sel
//   y        : gate outputs, one per channel
//   y_valid  : y holds fully pipelined data under the current function
// master = stimulus side, slave = the gate array.
interface multi_gate_array_if #(
  parameter int CHANNELS = 4,
  parameter int INPUTS   = 2
);
  logic [CHANNELS*INPUTS-1:0] a;
  logic                       en;
  logic [2:0]                 fn_sel;
  logic                       fn_load;
  logic [CHANNELS-1:0]        y;
  logic                       y_valid;

  modport master (output a, en, fn_sel, fn_load, input  y, y_valid);
  modport slave  (input  a, en, fn_sel, fn_load, output y, y_valid);
endinterface

// File: rtl/gate_glitch_filter.sv
// One channel of the optional output glitch filter.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_en       : advance enable; counter and output hold when low
//   i_r        : final pipeline stage bit for this channel
//   o_y        : filtered output, follows i_r only after it has differed
//                from o_y for FILTER_CYC consecutive enabled edges
module gate_glitch_filter
  import gate_array_pkg::*;
#(
  parameter int FILTER_CYC = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_r,
  output logic o_y
);

  logic [FCNT_W-1:0] r_cnt;
  logic              r_y;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_y   <= 1'b0;
    end else if (i_en) begin
      if (i_r == r_y) begin
        r_cnt <= '0;
      end else if (r_cnt == FCNT_W'(FILTER_CYC - 1)) begin
        r_y   <= i_r;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + FCNT_W'(1);
      end
    end
  end

  assign o_y = r_y;

endmodule

// File: rtl/multi_gate_array.sv
// CHANNELS independent INPUTS-input gates sharing one runtime-selected
// function, with the propagation delay modelled as DELAY_CYC pipeline stages.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : multi_gate_array_if slave (a, en, fn_sel, fn_load, y, y_valid)
// Build option: define GATE_FILTER_EN to add a per-channel glitch filter on
// the pipeline output; y_valid is then delayed by FILTER_CYC more edges.
module multi_gate_array
  import gate_array_pkg::*;
#(
  parameter int       CHANNELS   = 4,
  parameter int       INPUTS     = 2,
  parameter int       DELAY_CYC  = 1,
  parameter gate_fn_t RESET_FN   = FN_OR,
  parameter int       FILTER_CYC = 2
) (
  input  logic clk,
  input  logic rst_n,
  multi_gate_array_if.slave bus
);

`ifdef GATE_FILTER_EN
  localparam bit FILTER_EN = 1'b1;
`else
  localparam bit FILTER_EN = 1'b0;
`endif
  // The valid chain also covers the filter's settling time.
  localparam int VLD_LEN = DELAY_CYC + (FILTER_EN ? FILTER_CYC : 0);

  gate_fn_t            r_fn;
  logic                w_flush;
  logic [CHANNELS-1:0] w_eval;
  logic [CHANNELS-1:0] r_pipe [DELAY_CYC];
  logic [VLD_LEN-1:0]  r_vld;

  // A load changes the function only for samples taken on later edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fn <= RESET_FN;
    end else if (bus.fn_load) begin
      r_fn <= gate_fn_t'(bus.fn_sel);
    end
  end

  assign w_flush = bus.fn_load && (bus.fn_sel != r_fn);

  always_comb begin
    w_eval = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      w_eval[c] = gate_eval(r_fn, MAX_INPUTS'(bus.a[c*INPUTS +: INPUTS]), INPUTS);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DELAY_CYC; k++) r_pipe[k] <= '0;
    end else if (bus.en) begin
      r_pipe[0] <= w_eval;
      for (int k = 1; k < DELAY_CYC; k++) r_pipe[k] <= r_pipe[k-1];
    end
  end

  // A function change flushes validity even on an enabled edge, so the bit
  // that would have been shifted in on that edge is lost too.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
    end else if (w_flush) begin
      r_vld <= '0;
    end else if (bus.en) begin
      r_vld <= VLD_LEN'({r_vld, 1'b1});
    end
  end

`ifdef GATE_FILTER_EN
  logic [CHANNELS-1:0] w_y_filt;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_filt
    gate_glitch_filter #(
      .FILTER_CYC (FILTER_CYC)
    ) u_filt (
      .clk   (clk),
      .rst_n (rst_n),
      .i_en  (bus.en),
      .i_r   (r_pipe[DELAY_CYC-1][c]),
      .o_y   (w_y_filt[c])
    );
  end

  assign bus.y = w_y_filt;
`else
  assign bus.y = r_pipe[DELAY_CYC-1];
`endif

  assign bus.y_valid = r_vld[VLD_LEN-1];

endmodule
